mem_port_sequencer: RTL and testbench

- Sequences the single unified memory port of the multicycle RV32I core.
- Arbitrates between the instruction-fetch requester (IF) and the load/store requester (LS).
- Drives the memory-side request and holds it stable until the memory answers.
- Captures read data into an internal register and returns it to the owning requester with a one-cycle valid pulse.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_sequencer.sv | 154 +++++++++++++++
 tb/tb_mem_port_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port sequencer.
// Imported by mem_port_sequencer.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [3:0]  BE_WORD       = 4'hF;
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_port_sequencer.sv
// Arbitrates IF and LS requesters onto the single memory port of the multicycle core.
// Optional access timeout: define MEM_SEQ_TIMEOUT_EN.
module mem_port_sequencer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_PC_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mem_port_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  owner_t      owner_q, last_owner_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        grant_ls, grant_if;
  logic        timeout;

  // LS wins a tie unless it owned the previous access, so neither side starves.
  assign grant_ls = ls_req && (!if_req || (last_owner_q == OWN_IF));
  assign grant_if = if_req && !grant_ls;

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = rdata_q;
  assign ls_rdata  = rdata_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if_gnt = grant_if;
        ls_gnt = grant_ls;
        if (grant_if || grant_ls) state_d = ACCESS;
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ready || timeout) state_d = RESP;
      end
      RESP: begin
        if_rvalid = (owner_q == OWN_IF);
        ls_rvalid = (owner_q == OWN_LS);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture on grant; read-data capture on completion or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      rdata_q      <= RESET_PC_WORD;
    end else begin
      if (state_q == IDLE && (grant_if || grant_ls)) begin
        owner_q      <= grant_ls ? OWN_LS : OWN_IF;
        last_owner_q <= grant_ls ? OWN_LS : OWN_IF;
        if (grant_ls) begin
          addr_q  <= ls_addr;
          we_q    <= ls_we;
          be_q    <= ls_be;
          wdata_q <= ls_wdata;
        end else begin
          addr_q  <= if_addr;
          we_q    <= 1'b0;
          be_q    <= BE_WORD;
          wdata_q <= '0;
        end
      end
      if (state_q == ACCESS) begin
        if (mem_ready) begin
          if (!we_q) rdata_q <= mem_rdata;
        end else if (timeout) begin
          rdata_q <= TIMEOUT_RDATA;
        end
      end
    end
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_q;

  assign cnt_inc = cnt_q + CNT_W'(1);
  // The cycle that would bring the ready-less count to the limit aborts; mem_ready in it wins.
  assign timeout = (state_q == ACCESS) && !mem_ready && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
  assign err     = (state_q == RESP) && err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      if (!mem_ready) cnt_q <= cnt_inc;
      if (mem_ready || timeout) err_q <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed self-checking bench for mem_port_sequencer (inputs driven on negedge, outputs checked 1ns later).
// Exercises the timeout path when MEM_SEQ_TIMEOUT_EN is defined, the wait-forever path otherwise.
module tb_mem_port_sequencer;

  localparam logic [31:0] RST_WORD = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  // Control snapshot: {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, err}
  logic [5:0] ctl;
  assign ctl = {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, err};

  always #5 clk = ~clk;

  mem_port_sequencer #(
    .TIMEOUT_CYCLES(4),
    .RESET_PC_WORD (RST_WORD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_we     (ls_we),
    .ls_be     (ls_be),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_be = '0; ls_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000); end
    n_cmp++; if ({mem_we, mem_be} !== 5'b0) begin n_bad++; $display("FAIL reset_we_be: got %b expected %b", {mem_we, mem_be}, 5'b0); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_bad++; $display("FAIL reset_addr_wdata: got %h expected %h", {mem_addr, mem_wdata}, 64'h0); end
    n_cmp++; if ({if_rdata, ls_rdata} !== {RST_WORD, RST_WORD}) begin n_bad++; $display("FAIL reset_rdata: got %h expected %h", {if_rdata, ls_rdata}, {RST_WORD, RST_WORD}); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h100; #1;
    n_cmp++; if (ctl !== 6'b100000) begin n_bad++; $display("FAIL fetch_gnt: got %b expected %b", ctl, 6'b100000); end
    @(negedge clk); if_req = 1'b0; if_addr = 32'hFFFF_FFF0; #1;
    n_cmp++; if (ctl !== 6'b001000) begin n_bad++; $display("FAIL fetch_req: got %b expected %b", ctl, 6'b001000); end
    n_cmp++; if ({mem_addr, mem_we, mem_be, mem_wdata} !== {32'h100, 1'b0, 4'hF, 32'h0}) begin
      n_bad++; $display("FAIL fetch_bus: got %h/%b/%h/%h expected 00000100/0/f/00000000", mem_addr, mem_we, mem_be, mem_wdata);
    end
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h0050_0093; #1;
    n_cmp++; if (ctl !== 6'b001000) begin n_bad++; $display("FAIL fetch_ready_cycle: got %b expected %b", ctl, 6'b001000); end
    @(negedge clk); mem_ready = 1'b0; mem_rdata = '0; #1;
    n_cmp++; if (ctl !== 6'b000100) begin n_bad++; $display("FAIL fetch_rvalid: got %b expected %b", ctl, 6'b000100); end
    n_cmp++; if ({if_rdata, ls_rdata} !== {32'h0050_0093, 32'h0050_0093}) begin n_bad++; $display("FAIL fetch_rdata: got %h expected %h", {if_rdata, ls_rdata}, {32'h0050_0093, 32'h0050_0093}); end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL fetch_idle: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_alternation();
    logic [2:0]  to_ls = 3'b101;
    logic [5:0]  exp_g, exp_r;
    logic [31:0] exp_a;
    if_addr = 32'h104; ls_addr = 32'h400; ls_we = 1'b0; ls_be = 4'hF; ls_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      exp_g = to_ls[k] ? 6'b010000 : 6'b100000;
      exp_r = to_ls[k] ? 6'b000010 : 6'b000100;
      exp_a = to_ls[k] ? 32'h400 : 32'h104;
      @(negedge clk); if_req = 1'b1; ls_req = 1'b1; #1;
      n_cmp++; if (ctl !== exp_g) begin n_bad++; $display("FAIL alt_gnt[%0d]: got %b expected %b", k, ctl, exp_g); end
      @(negedge clk);
      if (k == 2) begin if_req = 1'b0; ls_req = 1'b0; end
      mem_ready = 1'b1; mem_rdata = 32'h1000_0000 + 32'(k); #1;
      n_cmp++; if ({ctl, mem_addr} !== {6'b001000, exp_a}) begin n_bad++; $display("FAIL alt_access[%0d]: got %b/%h expected %b/%h", k, ctl, mem_addr, 6'b001000, exp_a); end
      @(negedge clk); mem_ready = 1'b0; #1;
      n_cmp++; if (ctl !== exp_r) begin n_bad++; $display("FAIL alt_rvalid[%0d]: got %b expected %b", k, ctl, exp_r); end
      n_cmp++; if (ls_rdata !== 32'h1000_0000 + 32'(k)) begin n_bad++; $display("FAIL alt_rdata[%0d]: got %h expected %h", k, ls_rdata, 32'h1000_0000 + 32'(k)); end
    end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL alt_idle: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_store_waits();
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h200; ls_wdata = 32'hCAFE_1234; #1;
    n_cmp++; if (ctl !== 6'b010000) begin n_bad++; $display("FAIL store_gnt: got %b expected %b", ctl, 6'b010000); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'hC; ls_addr = 32'hBAD0; ls_wdata = '0;
      if_req = (c == 2);
      mem_ready = (c == 4); mem_rdata = 32'hDEAD_BEEF; #1;
      n_cmp++; if (ctl !== 6'b001000) begin n_bad++; $display("FAIL store_ctl[%0d]: got %b expected %b", c, ctl, 6'b001000); end
      n_cmp++; if ({mem_addr, mem_we, mem_be, mem_wdata} !== {32'h200, 1'b1, 4'b0011, 32'hCAFE_1234}) begin
        n_bad++; $display("FAIL store_bus[%0d]: got %h/%b/%h/%h expected 00000200/1/3/cafe1234", c, mem_addr, mem_we, mem_be, mem_wdata);
      end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (ctl !== 6'b000010) begin n_bad++; $display("FAIL store_rvalid: got %b expected %b", ctl, 6'b000010); end
    n_cmp++; if (ls_rdata !== 32'h1000_0002) begin n_bad++; $display("FAIL store_rdata_kept: got %h expected %h", ls_rdata, 32'h1000_0002); end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL store_idle: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_stray_and_drop();
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000; #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL stray_ready0: got %b expected %b", ctl, 6'b000000); end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL stray_ready1: got %b expected %b", ctl, 6'b000000); end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if ({ctl, if_rdata} !== {6'b000000, 32'h1000_0002}) begin n_bad++; $display("FAIL stray_rdata: got %b/%h expected %b/%h", ctl, if_rdata, 6'b000000, 32'h1000_0002); end
    // LS raises and drops its request while IF's access is in flight.
    @(negedge clk); if_req = 1'b1; if_addr = 32'h108; #1;
    n_cmp++; if (ctl !== 6'b100000) begin n_bad++; $display("FAIL drop_if_gnt: got %b expected %b", ctl, 6'b100000); end
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600;
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222; #1;
    n_cmp++; if (ctl !== 6'b001000) begin n_bad++; $display("FAIL drop_access: got %b expected %b", ctl, 6'b001000); end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if ({ctl, if_rdata} !== {6'b000100, 32'h1111_2222}) begin n_bad++; $display("FAIL drop_resp: got %b/%h expected %b/%h", ctl, if_rdata, 6'b000100, 32'h1111_2222); end
    ls_req = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL drop_no_gnt: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk); ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h300; #1;
    n_cmp++; if (ctl !== 6'b010000) begin n_bad++; $display("FAIL rst_mid_gnt: got %b expected %b", ctl, 6'b010000); end
    @(negedge clk); ls_req = 1'b0; #1;
    n_cmp++; if (ctl !== 6'b001000) begin n_bad++; $display("FAIL rst_mid_access: got %b expected %b", ctl, 6'b001000); end
    #2; reset_n = 1'b0; #1;
    n_cmp++; if ({ctl, mem_addr} !== {6'b000000, 32'h0}) begin n_bad++; $display("FAIL rst_mid_drop: got %b/%h expected %b/%h", ctl, mem_addr, 6'b000000, 32'h0); end
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL rst_mid_held: got %b expected %b", ctl, 6'b000000); end
    mem_ready = 1'b0;
    @(negedge clk); reset_n = 1'b1; #1;
    n_cmp++; if ({ctl, ls_rdata} !== {6'b000000, RST_WORD}) begin n_bad++; $display("FAIL rst_mid_release: got %b/%h expected %b/%h", ctl, ls_rdata, 6'b000000, RST_WORD); end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL rst_mid_no_resp: got %b expected %b", ctl, 6'b000000); end
    // last_owner is back to IF, so a tie now goes to LS.
    @(negedge clk); if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h10C; ls_addr = 32'h310; #1;
    n_cmp++; if (ctl !== 6'b010000) begin n_bad++; $display("FAIL rst_tie_gnt: got %b expected %b", ctl, 6'b010000); end
    @(negedge clk); if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h3333_4444; #1;
    n_cmp++; if ({ctl, mem_addr} !== {6'b001000, 32'h310}) begin n_bad++; $display("FAIL rst_tie_access: got %b/%h expected %b/%h", ctl, mem_addr, 6'b001000, 32'h310); end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if ({ctl, ls_rdata} !== {6'b000010, 32'h3333_4444}) begin n_bad++; $display("FAIL rst_tie_resp: got %b/%h expected %b/%h", ctl, ls_rdata, 6'b000010, 32'h3333_4444); end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL rst_tie_idle: got %b expected %b", ctl, 6'b000000); end
  endtask

`ifdef MEM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500; #1;
    n_cmp++; if (ctl !== 6'b010000) begin n_bad++; $display("FAIL to_gnt: got %b expected %b", ctl, 6'b010000); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); ls_req = 1'b0; mem_ready = 1'b0; #1;
      n_cmp++; if (ctl !== 6'b001000) begin n_bad++; $display("FAIL to_wait[%0d]: got %b expected %b", c, ctl, 6'b001000); end
    end
    @(negedge clk); #1;
    n_cmp++; if ({ctl, ls_rdata} !== {6'b000011, 32'h0}) begin n_bad++; $display("FAIL to_abort: got %b/%h expected %b/%h", ctl, ls_rdata, 6'b000011, 32'h0); end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL to_idle: got %b expected %b", ctl, 6'b000000); end
    @(negedge clk); ls_req = 1'b1; #1;
    n_cmp++; if (ctl !== 6'b010000) begin n_bad++; $display("FAIL to_edge_gnt: got %b expected %b", ctl, 6'b010000); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); ls_req = 1'b0; mem_ready = (c == 4); mem_rdata = 32'hABCD_0001; #1;
      n_cmp++; if (ctl !== 6'b001000) begin n_bad++; $display("FAIL to_edge_wait[%0d]: got %b expected %b", c, ctl, 6'b001000); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if ({ctl, ls_rdata} !== {6'b000010, 32'hABCD_0001}) begin n_bad++; $display("FAIL to_edge_resp: got %b/%h expected %b/%h", ctl, ls_rdata, 6'b000010, 32'hABCD_0001); end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL to_edge_idle: got %b expected %b", ctl, 6'b000000); end
  endtask
`else
  task automatic test_no_timeout();
    @(negedge clk); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500; #1;
    n_cmp++; if (ctl !== 6'b010000) begin n_bad++; $display("FAIL wait_gnt: got %b expected %b", ctl, 6'b010000); end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); ls_req = 1'b0; mem_ready = (c == 20); mem_rdata = 32'hABCD_0001; #1;
      n_cmp++; if (ctl !== 6'b001000) begin n_bad++; $display("FAIL wait_hold[%0d]: got %b expected %b", c, ctl, 6'b001000); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if ({ctl, ls_rdata} !== {6'b000010, 32'hABCD_0001}) begin n_bad++; $display("FAIL wait_resp: got %b/%h expected %b/%h", ctl, ls_rdata, 6'b000010, 32'hABCD_0001); end
    @(negedge clk); #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL wait_idle: got %b expected %b", ctl, 6'b000000); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_fetch();
    test_alternation();
    test_store_waits();
    test_stray_and_drop();
    test_reset_mid_access();
`ifdef MEM_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
